// File: rtl/issue_queue_param_if.sv
// Dispatch, writeback-broadcast and issue signals of the unified issue queue.
// The dispatch/FU side uses master; the queue uses slave.
interface issue_queue_param_if #(
  parameter int NUM_FU = 3,
  parameter int NUM_WB = 3,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 6,
  parameter int OP_W   = 4
);
  localparam int FU_W = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic                     disp_valid;
  logic                     disp_ready;
  logic [DATA_W-1:0]        disp_pc;
  logic [OP_W-1:0]          disp_optype;
  logic [FU_W-1:0]          disp_fu;
  logic [TAG_W-1:0]         disp_src1_tag;
  logic [TAG_W-1:0]         disp_src2_tag;
  logic                     disp_src1_rdy;
  logic                     disp_src2_rdy;
  logic [DATA_W-1:0]        disp_src1_data;
  logic [DATA_W-1:0]        disp_src2_data;
  logic [DATA_W-1:0]        disp_imm;
  logic [TAG_W-1:0]         disp_dest_tag;
  logic [ROB_W-1:0]         disp_rob;

  logic [NUM_WB-1:0]        wb_valid;
  logic [NUM_WB*TAG_W-1:0]  wb_tag;
  logic [NUM_WB*DATA_W-1:0] wb_data;

  logic [NUM_FU-1:0]        fu_ready;
  logic [NUM_FU-1:0]        iss_valid;
  logic [NUM_FU*DATA_W-1:0] iss_pc;
  logic [NUM_FU*DATA_W-1:0] iss_src1_data;
  logic [NUM_FU*DATA_W-1:0] iss_src2_data;
  logic [NUM_FU*DATA_W-1:0] iss_imm;
  logic [NUM_FU*OP_W-1:0]   iss_optype;
  logic [NUM_FU*TAG_W-1:0]  iss_dest_tag;
  logic [NUM_FU*ROB_W-1:0]  iss_rob;

  modport master (
    output disp_valid, disp_pc, disp_optype, disp_fu,
           disp_src1_tag, disp_src2_tag, disp_src1_rdy, disp_src2_rdy,
           disp_src1_data, disp_src2_data, disp_imm, disp_dest_tag, disp_rob,
           wb_valid, wb_tag, wb_data, fu_ready,
    input  disp_ready, iss_valid, iss_pc, iss_src1_data, iss_src2_data,
           iss_imm, iss_optype, iss_dest_tag, iss_rob
  );

  modport slave (
    input  disp_valid, disp_pc, disp_optype, disp_fu,
           disp_src1_tag, disp_src2_tag, disp_src1_rdy, disp_src2_rdy,
           disp_src1_data, disp_src2_data, disp_imm, disp_dest_tag, disp_rob,
           wb_valid, wb_tag, wb_data, fu_ready,
    output disp_ready, iss_valid, iss_pc, iss_src1_data, iss_src2_data,
           iss_imm, iss_optype, iss_dest_tag, iss_rob
  );
endinterface

// File: rtl/issue_queue_param.sv
// Parametrised age-ordered unified issue queue: captures operands from writeback
// broadcasts and issues the oldest ready entry per functional unit each cycle.
module issue_queue_param #(
  parameter int DEPTH  = 16,
  parameter int NUM_FU = 3,
  parameter int NUM_WB = 3,
  parameter int TAG_W  = 6,
  parameter int DATA_W = 32,
  parameter int ROB_W  = 6,
  parameter int OP_W   = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  issue_queue_param_if.slave         bus,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full
);
  localparam int CNT_W = $clog2(DEPTH+1);
  localparam int IDX_W = $clog2(DEPTH);
  localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;

  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_rdy1;
  logic [DEPTH-1:0]  ent_rdy2;
  // age[i][j] = 1 means entry j was dispatched before entry i
  logic [DEPTH-1:0]  age       [DEPTH];
  logic [DATA_W-1:0] ent_pc    [DEPTH];
  logic [OP_W-1:0]   ent_op    [DEPTH];
  logic [FU_W-1:0]   ent_fu    [DEPTH];
  logic [TAG_W-1:0]  ent_tag1  [DEPTH];
  logic [TAG_W-1:0]  ent_tag2  [DEPTH];
  logic [DATA_W-1:0] ent_data1 [DEPTH];
  logic [DATA_W-1:0] ent_data2 [DEPTH];
  logic [DATA_W-1:0] ent_imm   [DEPTH];
  logic [TAG_W-1:0]  ent_dest  [DEPTH];
  logic [ROB_W-1:0]  ent_rob   [DEPTH];

  logic              enq;
  logic [IDX_W-1:0]  enq_slot;
  logic              disp_hit1;
  logic              disp_hit2;
  logic [DATA_W-1:0] disp_wbd1;
  logic [DATA_W-1:0] disp_wbd2;
  logic [DEPTH-1:0]  hit1;
  logic [DEPTH-1:0]  hit2;
  logic [DATA_W-1:0] wbd1 [DEPTH];
  logic [DATA_W-1:0] wbd2 [DEPTH];
  logic [DEPTH-1:0]  elig [NUM_FU];
  logic [DEPTH-1:0]  sel  [NUM_FU];
  logic [NUM_FU-1:0] sel_any;
  logic [IDX_W-1:0]  sel_idx [NUM_FU];
  logic [DEPTH-1:0]  issued;
  logic [CNT_W-1:0]  n_iss;
  logic [CNT_W-1:0]  count_next;

  // Returns {hit, data}; scanning downwards lets the lowest matching port win.
  function automatic logic [DATA_W:0] wb_match(
    input logic [TAG_W-1:0]         tag,
    input logic [NUM_WB-1:0]        vld,
    input logic [NUM_WB*TAG_W-1:0]  tags,
    input logic [NUM_WB*DATA_W-1:0] data
  );
    logic [DATA_W:0] r;
    r = '0;
    for (int p = NUM_WB - 1; p >= 0; p--) begin
      if (vld[p] && (tags[p*TAG_W +: TAG_W] == tag)) begin
        r = {1'b1, data[p*DATA_W +: DATA_W]};
      end
    end
    return r;
  endfunction

  assign full           = (count == CNT_W'(DEPTH));
  assign bus.disp_ready = ~full;
  assign enq            = bus.disp_valid & ~full & (|bus.disp_optype) & ~flush;

  always_comb begin
    enq_slot = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!ent_valid[i]) begin
        enq_slot = IDX_W'(i);
      end
    end
  end

  always_comb begin
    {disp_hit1, disp_wbd1} = wb_match(bus.disp_src1_tag, bus.wb_valid, bus.wb_tag, bus.wb_data);
    {disp_hit2, disp_wbd2} = wb_match(bus.disp_src2_tag, bus.wb_valid, bus.wb_tag, bus.wb_data);
    for (int i = 0; i < DEPTH; i++) begin
      {hit1[i], wbd1[i]} = wb_match(ent_tag1[i], bus.wb_valid, bus.wb_tag, bus.wb_data);
      {hit2[i], wbd2[i]} = wb_match(ent_tag2[i], bus.wb_valid, bus.wb_tag, bus.wb_data);
    end
  end

  always_comb begin
    for (int f = 0; f < NUM_FU; f++) begin
      for (int i = 0; i < DEPTH; i++) begin
        elig[f][i] = ent_valid[i] & ent_rdy1[i] & ent_rdy2[i] &
                     (ent_fu[i] == FU_W'(f)) & bus.fu_ready[f];
      end
    end
  end

  // An eligible entry wins its FU when no other eligible entry of that FU is older.
  always_comb begin
    issued = '0;
    n_iss  = '0;
    for (int f = 0; f < NUM_FU; f++) begin
      sel_any[f] = 1'b0;
      sel_idx[f] = '0;
      for (int i = 0; i < DEPTH; i++) begin
        sel[f][i] = elig[f][i] & ~(|(elig[f] & age[i]));
        if (sel[f][i]) begin
          sel_any[f] = 1'b1;
          sel_idx[f] = IDX_W'(i);
        end
      end
      issued = issued | sel[f];
      n_iss  = n_iss + CNT_W'(sel_any[f]);
    end
    count_next = count + CNT_W'(enq) - n_iss;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ent_valid         <= '0;
      count             <= '0;
      bus.iss_valid     <= '0;
      bus.iss_pc        <= '0;
      bus.iss_src1_data <= '0;
      bus.iss_src2_data <= '0;
      bus.iss_imm       <= '0;
      bus.iss_optype    <= '0;
      bus.iss_dest_tag  <= '0;
      bus.iss_rob       <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        age[i] <= '0;
      end
    end else if (flush) begin
      ent_valid     <= '0;
      count         <= '0;
      bus.iss_valid <= '0;
    end else begin
      ent_valid <= (ent_valid & ~issued) | (enq ? (DEPTH'(1) << enq_slot) : '0);
      count     <= count_next;
      // New entry is younger than everything currently valid.
      if (enq) begin
        for (int j = 0; j < DEPTH; j++) begin
          age[j][enq_slot] <= 1'b0;
        end
        age[enq_slot] <= ent_valid;
      end
      for (int f = 0; f < NUM_FU; f++) begin
        bus.iss_valid[f] <= sel_any[f];
        if (sel_any[f]) begin
          bus.iss_pc[f*DATA_W +: DATA_W]        <= ent_pc[sel_idx[f]];
          bus.iss_src1_data[f*DATA_W +: DATA_W] <= ent_data1[sel_idx[f]];
          bus.iss_src2_data[f*DATA_W +: DATA_W] <= ent_data2[sel_idx[f]];
          bus.iss_imm[f*DATA_W +: DATA_W]       <= ent_imm[sel_idx[f]];
          bus.iss_optype[f*OP_W +: OP_W]        <= ent_op[sel_idx[f]];
          bus.iss_dest_tag[f*TAG_W +: TAG_W]    <= ent_dest[sel_idx[f]];
          bus.iss_rob[f*ROB_W +: ROB_W]         <= ent_rob[sel_idx[f]];
        end
      end
    end
  end

  // Payload and operand readiness: dispatch write (with same-cycle bypass) or wakeup capture.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ent_rdy1 <= '0;
      ent_rdy2 <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_pc[i]    <= '0;
        ent_op[i]    <= '0;
        ent_fu[i]    <= '0;
        ent_tag1[i]  <= '0;
        ent_tag2[i]  <= '0;
        ent_data1[i] <= '0;
        ent_data2[i] <= '0;
        ent_imm[i]   <= '0;
        ent_dest[i]  <= '0;
        ent_rob[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (enq && (enq_slot == IDX_W'(i))) begin
          ent_pc[i]    <= bus.disp_pc;
          ent_op[i]    <= bus.disp_optype;
          ent_fu[i]    <= bus.disp_fu;
          ent_tag1[i]  <= bus.disp_src1_tag;
          ent_tag2[i]  <= bus.disp_src2_tag;
          ent_imm[i]   <= bus.disp_imm;
          ent_dest[i]  <= bus.disp_dest_tag;
          ent_rob[i]   <= bus.disp_rob;
          ent_rdy1[i]  <= bus.disp_src1_rdy | disp_hit1;
          ent_rdy2[i]  <= bus.disp_src2_rdy | disp_hit2;
          ent_data1[i] <= bus.disp_src1_rdy ? bus.disp_src1_data : disp_wbd1;
          ent_data2[i] <= bus.disp_src2_rdy ? bus.disp_src2_data : disp_wbd2;
        end else if (ent_valid[i]) begin
          if (!ent_rdy1[i] && hit1[i]) begin
            ent_rdy1[i]  <= 1'b1;
            ent_data1[i] <= wbd1[i];
          end
          if (!ent_rdy2[i] && hit2[i]) begin
            ent_rdy2[i]  <= 1'b1;
            ent_data2[i] <= wbd2[i];
          end
        end
      end
    end
  end
endmodule

// File: tb/tb_issue_queue_param.sv
// Directed bench for issue_queue_param: dispatch, wakeup/bypass, age order,
// backpressure, parallel issue, flush and asynchronous reset.
module tb_issue_queue_param;
  logic       clk;
  logic       rstn;
  logic       flush;
  logic [4:0] count;
  logic       full;
  int         vec_count;
  int         miscompares;

  issue_queue_param_if #(.NUM_FU(3), .NUM_WB(3), .TAG_W(6), .DATA_W(32), .ROB_W(6), .OP_W(4)) bus ();

  issue_queue_param #(
    .DEPTH(16), .NUM_FU(3), .NUM_WB(3), .TAG_W(6), .DATA_W(32), .ROB_W(6), .OP_W(4)
  ) dut (
    .clk   (clk),
    .rstn  (rstn),
    .flush (flush),
    .bus   (bus),
    .count (count),
    .full  (full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_count++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offers one instruction for a single clock edge.
  task automatic applyStimulus(input logic [3:0] op, input logic [1:0] fu,
                               input logic [5:0] t1, input logic r1, input logic [31:0] d1,
                               input logic [5:0] t2, input logic r2, input logic [31:0] d2,
                               input logic [5:0] rob);
    bus.disp_valid     = 1'b1;
    bus.disp_optype    = op;
    bus.disp_fu        = fu;
    bus.disp_src1_tag  = t1;
    bus.disp_src1_rdy  = r1;
    bus.disp_src1_data = d1;
    bus.disp_src2_tag  = t2;
    bus.disp_src2_rdy  = r2;
    bus.disp_src2_data = d2;
    bus.disp_pc        = 32'h1000 + 32'(rob);
    bus.disp_imm       = 32'hA000 + 32'(rob);
    bus.disp_dest_tag  = rob;
    bus.disp_rob       = rob;
    tick();
    bus.disp_valid = 1'b0;
  endtask

  task automatic wbSet(input int p, input logic [5:0] tag, input logic [31:0] data);
    bus.wb_valid[p]          = 1'b1;
    bus.wb_tag[p*6 +: 6]     = tag;
    bus.wb_data[p*32 +: 32]  = data;
  endtask

  function automatic logic [5:0] robLane(input int f);
    return bus.iss_rob[f*6 +: 6];
  endfunction

  initial begin
    vec_count   = 0;
    miscompares = 0;
    rstn  = 1'b0;
    flush = 1'b0;
    bus.disp_valid = 1'b0;
    bus.disp_pc = '0; bus.disp_optype = '0; bus.disp_fu = '0;
    bus.disp_src1_tag = '0; bus.disp_src2_tag = '0;
    bus.disp_src1_rdy = 1'b0; bus.disp_src2_rdy = 1'b0;
    bus.disp_src1_data = '0; bus.disp_src2_data = '0;
    bus.disp_imm = '0; bus.disp_dest_tag = '0; bus.disp_rob = '0;
    bus.wb_valid = '0; bus.wb_tag = '0; bus.wb_data = '0;
    bus.fu_ready = 3'b000;
    #3;
    checkOutput("rst_count", 64'(count), 0);
    checkOutput("rst_full", 64'(full), 0);
    checkOutput("rst_ready", 64'(bus.disp_ready), 1);
    checkOutput("rst_iss_valid", 64'(bus.iss_valid), 0);
    #9 rstn = 1'b1;
    tick();

    // Single dispatch; optype 0 is dropped first
    bus.fu_ready = 3'b111;
    applyStimulus(4'd0, 2'd0, 6'd1, 1'b1, 32'd9, 6'd2, 1'b1, 32'd9, 6'd63);
    checkOutput("op0_count", 64'(count), 0);
    applyStimulus(4'd1, 2'd0, 6'd1, 1'b1, 32'd5, 6'd2, 1'b1, 32'd7, 6'd1);
    checkOutput("t1_count_after_enq", 64'(count), 1);
    checkOutput("t1_no_early_issue", 64'(bus.iss_valid), 0);
    tick();
    checkOutput("t1_iss_valid", 64'(bus.iss_valid), 3'b001);
    checkOutput("t1_src1", 64'(bus.iss_src1_data[31:0]), 5);
    checkOutput("t1_src2", 64'(bus.iss_src2_data[31:0]), 7);
    checkOutput("t1_pc", 64'(bus.iss_pc[31:0]), 32'h1001);
    checkOutput("t1_imm", 64'(bus.iss_imm[31:0]), 32'hA001);
    checkOutput("t1_optype", 64'(bus.iss_optype[3:0]), 1);
    checkOutput("t1_count_after_iss", 64'(count), 0);
    tick();
    checkOutput("t1_pulse_drops", 64'(bus.iss_valid), 0);
    checkOutput("t1_src1_hold", 64'(bus.iss_src1_data[31:0]), 5);

    // Wakeup: src2 shares the tag but is already ready and must keep its value
    applyStimulus(4'd2, 2'd0, 6'd12, 1'b0, 32'd0, 6'd12, 1'b1, 32'd3, 6'd2);
    tick();
    tick();
    checkOutput("t2_waiting", 64'(bus.iss_valid), 0);
    wbSet(1, 6'd12, 32'hDEAD);
    wbSet(2, 6'd12, 32'hBEEF);
    tick();
    bus.wb_valid = '0;
    checkOutput("t2_not_yet", 64'(bus.iss_valid), 0);
    tick();
    checkOutput("t2_iss_valid", 64'(bus.iss_valid), 3'b001);
    checkOutput("t2_src1_woken", 64'(bus.iss_src1_data[31:0]), 32'hDEAD);
    checkOutput("t2_src2_kept", 64'(bus.iss_src2_data[31:0]), 3);
    checkOutput("t2_rob", 64'(robLane(0)), 2);

    // Same-cycle bypass at dispatch
    wbSet(0, 6'd13, 32'h55);
    applyStimulus(4'd3, 2'd0, 6'd14, 1'b1, 32'd9, 6'd13, 1'b0, 32'd0, 6'd3);
    bus.wb_valid = '0;
    tick();
    checkOutput("t2b_iss_valid", 64'(bus.iss_valid), 3'b001);
    checkOutput("t2b_src2_bypass", 64'(bus.iss_src2_data[31:0]), 32'h55);
    checkOutput("t2b_rob", 64'(robLane(0)), 3);

    // Age order: A,B,C,D in slots 0..3, B leaves, E reuses slot 1
    bus.fu_ready = 3'b101;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'd1, 2'd1, 6'(30 + i), 1'b0, 32'd0, 6'd0, 1'b1, 32'd1, 6'(20 + i));
    end
    checkOutput("t3_count4", 64'(count), 4);
    bus.fu_ready = 3'b111;
    wbSet(0, 6'd31, 32'h31);
    tick();
    bus.wb_valid = '0;
    tick();
    checkOutput("t3_b_issue", 64'(bus.iss_valid), 3'b010);
    checkOutput("t3_b_rob", 64'(robLane(1)), 21);
    bus.fu_ready = 3'b101;
    applyStimulus(4'd1, 2'd1, 6'd0, 1'b1, 32'd2, 6'd0, 1'b1, 32'd2, 6'd24);
    checkOutput("t3_count_e", 64'(count), 4);
    wbSet(0, 6'd30, 32'h30);
    wbSet(1, 6'd32, 32'h32);
    wbSet(2, 6'd33, 32'h33);
    tick();
    bus.wb_valid = '0;
    tick();
    checkOutput("t3_blocked", 64'(bus.iss_valid), 0);
    bus.fu_ready = 3'b111;
    tick();
    checkOutput("t3_first_a", 64'(robLane(1)), 20);
    tick();
    checkOutput("t3_second_c", 64'(robLane(1)), 22);
    tick();
    checkOutput("t3_third_d", 64'(robLane(1)), 23);
    tick();
    checkOutput("t3_last_e", 64'(robLane(1)), 24);
    checkOutput("t3_last_valid", 64'(bus.iss_valid), 3'b010);
    tick();
    checkOutput("t3_drained", 64'(count), 0);

    // Full and backpressure
    for (int i = 0; i < 16; i++) begin
      applyStimulus(4'd1, 2'd0, 6'(40 + i), 1'b0, 32'd0, 6'd0, 1'b1, 32'd0, 6'(i));
    end
    checkOutput("t4_count16", 64'(count), 16);
    checkOutput("t4_full", 64'(full), 1);
    checkOutput("t4_not_ready", 64'(bus.disp_ready), 0);
    applyStimulus(4'd1, 2'd0, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd40);
    checkOutput("t4_17th_rejected", 64'(count), 16);
    wbSet(0, 6'd40, 32'h40);
    tick();
    bus.wb_valid = '0;
    tick();
    checkOutput("t4_iss", 64'(bus.iss_valid), 3'b001);
    checkOutput("t4_iss_rob", 64'(robLane(0)), 0);
    tick();
    checkOutput("t4_ready_again", 64'(bus.disp_ready), 1);
    checkOutput("t4_full_clear", 64'(full), 0);
    checkOutput("t4_count15", 64'(count), 15);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checkOutput("t4_flush_count", 64'(count), 0);

    // Parallel issue across all three FUs
    bus.fu_ready = 3'b000;
    applyStimulus(4'd1, 2'd0, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd10);
    applyStimulus(4'd2, 2'd1, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd11);
    applyStimulus(4'd3, 2'd2, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd12);
    applyStimulus(4'd1, 2'd0, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd13);
    bus.fu_ready = 3'b111;
    tick();
    checkOutput("t5_all_valid", 64'(bus.iss_valid), 3'b111);
    checkOutput("t5_rob_fu0", 64'(robLane(0)), 10);
    checkOutput("t5_rob_fu1", 64'(robLane(1)), 11);
    checkOutput("t5_rob_fu2", 64'(robLane(2)), 12);
    checkOutput("t5_count1", 64'(count), 1);
    tick();
    checkOutput("t5_second_valid", 64'(bus.iss_valid), 3'b001);
    checkOutput("t5_second_rob", 64'(robLane(0)), 13);
    tick();

    // Flush overrides a same-cycle dispatch and issue
    bus.fu_ready = 3'b000;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(4'd1, 2'd0, 6'(50 + i), 1'b0, 32'd0, 6'd0, 1'b1, 32'd0, 6'(30 + i));
    end
    applyStimulus(4'd1, 2'd0, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd34);
    checkOutput("t6_count5", 64'(count), 5);
    bus.fu_ready = 3'b111;
    flush = 1'b1;
    applyStimulus(4'd1, 2'd1, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd35);
    flush = 1'b0;
    checkOutput("t6_count0", 64'(count), 0);
    checkOutput("t6_no_issue", 64'(bus.iss_valid), 0);
    wbSet(0, 6'd50, 32'h50);
    tick();
    bus.wb_valid = '0;
    tick();
    checkOutput("t6_still_empty", 64'(count), 0);
    checkOutput("t6_still_no_issue", 64'(bus.iss_valid), 0);

    // Asynchronous reset between clock edges
    bus.fu_ready = 3'b000;
    applyStimulus(4'd1, 2'd0, 6'd0, 1'b1, 32'd0, 6'd0, 1'b1, 32'd0, 6'd7);
    applyStimulus(4'd1, 2'd0, 6'd60, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0, 6'd8);
    bus.fu_ready = 3'b111;
    tick();
    checkOutput("t7_pre_valid", 64'(bus.iss_valid), 3'b001);
    checkOutput("t7_pre_count", 64'(count), 1);
    #2 rstn = 1'b0;
    #1;
    checkOutput("t7_async_valid", 64'(bus.iss_valid), 0);
    checkOutput("t7_async_count", 64'(count), 0);
    checkOutput("t7_async_rob", 64'(robLane(0)), 0);
    checkOutput("t7_async_ready", 64'(bus.disp_ready), 1);
    #2 rstn = 1'b1;
    tick();
    checkOutput("t7_post_count", 64'(count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
    $finish;
  end
endmodule

// File: doc/issue_queue_param.md
Name: issue_queue_param

Overview:
- Parametrised, age-ordered unified issue queue. Successor to the fixed 64-entry, 3-ALU UIQ.
- Sits between dispatch/rename and the functional units.
- Accepts one renamed instruction per cycle through a valid/ready handshake.
- Captures operands from NUM_WB writeback broadcast ports (tag match = wakeup).
- Each cycle, issues to every ready FU the oldest entry that is operand-ready and bound to that FU.
- Supports synchronous pipeline flush.

Parameters:
DEPTH, 16, number of queue entries (2..64)
NUM_FU, 3, number of functional units / issue ports
NUM_WB, 3, number of writeback broadcast ports
TAG_W, 6, physical register tag width
DATA_W, 32, operand/PC/immediate width
ROB_W, 6, ROB index width
OP_W, 4, optype width

Ports:
clk  in  1  clock
rstn  in  1  reset, asynchronous, active-low
flush  in  1  synchronous clear of all entries
disp_valid  in  1  dispatch offers an instruction
disp_ready  out  1  queue can accept (= ~full)
disp_pc  in  DATA_W  instruction PC
disp_optype  in  OP_W  decoded optype (0 = invalid; never enqueued)
disp_fu  in  clog2(NUM_FU)  FU binding chosen by dispatch
disp_src1_tag/disp_src2_tag  in  TAG_W each  source physical tags
disp_src1_rdy/disp_src2_rdy  in  1 each  source value already valid
disp_src1_data/disp_src2_data  in  DATA_W each  source value when rdy
disp_imm  in  DATA_W  immediate
disp_dest_tag  in  TAG_W  destination physical tag
disp_rob  in  ROB_W  ROB index
wb_valid  in  NUM_WB  broadcast valid per port
wb_tag  in  NUM_WB*TAG_W  broadcast tags, port p at [p*TAG_W +: TAG_W]
wb_data  in  NUM_WB*DATA_W  broadcast values
fu_ready  in  NUM_FU  FU f can accept an issue this cycle
iss_valid  out  NUM_FU  one-cycle issue pulse per FU
iss_pc, iss_src1_data, iss_src2_data, iss_imm  out  NUM_FU*DATA_W each  issued fields
iss_optype  out  NUM_FU*OP_W  issued optype
iss_dest_tag  out  NUM_FU*TAG_W  issued destination tag
iss_rob  out  NUM_FU*ROB_W  issued ROB index
count  out  clog2(DEPTH+1)  number of valid entries
full  out  1  count == DEPTH

Behaviour:
- Reset (async): all entry valid bits = 0; age state cleared; all iss_* = 0; count = 0; full = 0; disp_ready = 1.
- Enqueue on rising edge when disp_valid & disp_ready & optype != 0 & ~flush. Entry goes to the lowest-index free slot.
- disp_ready and full are derived from registered count only. A slot freed by issue in cycle N is usable in cycle N+1.
- Dispatch bypass: if a dispatched source is not rdy and its tag matches a valid wb port in the same cycle, the entry stores that wb data with ready = 1.
- Entry wakeup: on each edge, every valid, not-ready source whose tag matches a valid wb port captures that data and sets ready.
  - If several wb ports match the same tag, the lowest port index wins.
  - Ready sources never re-capture.
- Select uses registered state only. An entry woken at edge N is eligible for selection during cycle N+1.
- Eligible = valid & src1_rdy & src2_rdy & fu_ready[entry.fu].
- Per FU, select the oldest eligible entry bound to that FU.
  - Age is tracked with a DEPTH×DEPTH age matrix. Oldest = dispatched earliest.
  - Never order by slot index.
- Issue latency: an entry selected in cycle N drives iss_valid[f] = 1 and its fields at cycle N+1 (registered outputs). The entry is freed at the same edge.
  - iss_valid deasserts the next cycle unless a new selection occurs.
  - iss data fields hold their last value when iss_valid = 0.
- At most one issue per FU per cycle. Up to NUM_FU issues per cycle total.
- Simultaneous enqueue and issue in the same cycle: count updates by (+1 − issued).
- Flush: at that edge all entries are invalidated, iss_valid = 0, count = 0. Flush overrides a same-cycle dispatch and issue.
- Deasserting rstn mid-operation clears everything immediately, independent of clk.
- Widths: count is wide enough for DEPTH. No tag/ROB arithmetic is performed; tags are compared only for equality.

Test Plan:
- Reset then single dispatch: ADD (optype 1), fu=0, both srcs rdy, data 5/7, fu_ready=3'b111 → iss_valid=3'b001 exactly 2 cycles after dispatch edge; iss_src1_data=5, iss_src2_data=7; count returns to 0.
- Wakeup: dispatch with src1_tag=12 not rdy; 3 cycles later wb_valid[1]=1, wb_tag[1]=12, wb_data[1]=0xDEAD → issue 2 cycles after the wb edge carries src1=0xDEAD. Same-cycle bypass case: issue 2 cycles after dispatch.
- Age order: fill slots 0..3 for fu=1, free slot 1 via issue, dispatch E (lands in slot 1), hold fu_ready[1]=0 with all ready, then release → issue order is dispatch order, not slot order; E issues last.
- Full/backpressure: DEPTH=16, dispatch 16 non-ready entries → full=1, disp_ready=0; 17th offer is not accepted. One wakeup+issue → disp_ready=1 the cycle after the issue pulse.
- Parallel issue: three ready entries bound to fu 0/1/2 plus a second fu-0 entry → iss_valid=3'b111 in one cycle, then 3'b001 the next cycle.
- Flush and async reset: flush with 5 valid entries and a same-cycle dispatch → count=0, no iss_valid afterwards. Assert rstn low mid-cycle → outputs zero before the next clk edge.
